// File: rtl/isqrt_arb_pkg.sv
// Shared definitions for the isqrt round-robin arbiter.
//   N_REQ / TAG_DEPTH : default requester count and outstanding-operation depth
//   req_idx_t         : requester index at the default N_REQ
//   isqrt_res_t       : 16-bit square-root result
package isqrt_arb_pkg;

  localparam int N_REQ     = 4;
  localparam int TAG_DEPTH = 8;

  typedef logic [$clog2(N_REQ)-1:0] req_idx_t;
  typedef logic [15:0]              isqrt_res_t;

endpackage

// File: rtl/isqrt_arb_tag_fifo.sv
// Tag FIFO remembering which requester owns each in-flight isqrt operation.
// The head entry is visible combinationally so that a result can be routed
// in the same cycle it arrives.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, din  : write a tag (ignored when full unless popping in the same cycle)
//   pop        : discard the head tag (ignored when empty)
//   full/empty : occupancy flags
//   head       : oldest tag
module isqrt_arb_tag_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = mem[rd_ptr_reg];

  // When full, a push is only legal alongside a pop: the head is read from
  // the old contents before the write lands on the same slot.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/isqrt_rr_arbiter.sv
// Round-robin arbiter sharing one in-order, non-backpressuring isqrt unit
// between N_REQ requesters, routing results back via a tag FIFO.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_x_vld/req_x : per-requester operand valid / packed operands (32 b each)
//   req_x_rdy       : one-hot grant, combinational
//   req_y_vld/req_y : per-requester result valid / broadcast 16-bit result
//   isqrt_x_vld/_x  : operand to the shared isqrt
//   isqrt_y_vld/_y  : result from the shared isqrt
//   err_orphan      : sticky, set by a result with no outstanding tag
//   perf_grants     : saturating 16-bit transfer counters per requester,
//                     present only when ISQRT_RR_ARBITER_PERF_EN is defined
module isqrt_rr_arbiter #(
  parameter int N_REQ     = isqrt_arb_pkg::N_REQ,
  parameter int TAG_DEPTH = isqrt_arb_pkg::TAG_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_x_vld,
  input  logic [N_REQ*32-1:0]   req_x,
  output logic [N_REQ-1:0]      req_x_rdy,
  output logic [N_REQ-1:0]      req_y_vld,
  output logic [15:0]           req_y,
  output logic                  isqrt_x_vld,
  output logic [31:0]           isqrt_x,
  input  logic                  isqrt_y_vld,
  input  logic [15:0]           isqrt_y,
  output logic                  err_orphan
`ifdef ISQRT_RR_ARBITER_PERF_EN
  ,
  output logic [N_REQ*16-1:0]   perf_grants
`endif
);

  import isqrt_arb_pkg::*;

  localparam int IDX_W = $clog2(N_REQ);

  logic [IDX_W-1:0] last_grant_reg;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_found;
  logic             xfer;
  logic             y_hit;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] fifo_head;
  logic             err_orphan_reg;
  isqrt_res_t       res_out;

  // Search from last_grant+1 so the most recent winner has lowest priority.
  always_comb begin
    int cand;
    grant_idx   = last_grant_reg;
    grant_found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_grant_reg) + k) % N_REQ;
      if (!grant_found && req_x_vld[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // A full FIFO still accepts a new tag when a result frees the head slot
  // in the same cycle. Everything is gated by rst_n so outputs read zero
  // for the whole time reset is held.
  assign xfer  = rst_n && grant_found && (!fifo_full || isqrt_y_vld);
  assign y_hit = rst_n && isqrt_y_vld && !fifo_empty;

  isqrt_arb_tag_fifo #(
    .DEPTH (TAG_DEPTH),
    .WIDTH (IDX_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (xfer),
    .din   (grant_idx),
    .pop   (y_hit),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign req_x_rdy[gi] = xfer && (grant_idx == IDX_W'(gi));
      assign req_y_vld[gi] = y_hit && (fifo_head == IDX_W'(gi));
    end
  endgenerate

  assign res_out     = rst_n ? isqrt_y : '0;
  assign req_y       = res_out;
  assign isqrt_x_vld = xfer;
  assign isqrt_x     = xfer ? req_x[32*grant_idx +: 32] : '0;
  assign err_orphan  = err_orphan_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= IDX_W'(N_REQ - 1);
      err_orphan_reg <= 1'b0;
    end else begin
      if (xfer) last_grant_reg <= grant_idx;
      if (isqrt_y_vld && fifo_empty) err_orphan_reg <= 1'b1;
    end
  end

`ifdef ISQRT_RR_ARBITER_PERF_EN
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_perf
      logic [15:0] cnt_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (req_x_rdy[gi] && (cnt_reg != 16'hFFFF)) begin
          cnt_reg <= cnt_reg + 16'd1;
        end
      end
      assign perf_grants[16*gi +: 16] = cnt_reg;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
module tb_isqrt_rr_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_x_vld;
  logic [N*32-1:0] req_x;
  logic [N-1:0]  req_x_rdy;
  logic [N-1:0]  req_y_vld;
  logic [15:0]   req_y;
  logic          isqrt_x_vld;
  logic [31:0]   isqrt_x;
  logic          isqrt_y_vld;
  logic [15:0]   isqrt_y;
  logic          err_orphan;
`ifdef ISQRT_RR_ARBITER_PERF_EN
  logic [N*16-1:0] perf_grants;
`endif

  int n_vec = 0;
  int n_err = 0;

  isqrt_rr_arbiter #(.N_REQ(4), .TAG_DEPTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_x_vld   (req_x_vld),
    .req_x       (req_x),
    .req_x_rdy   (req_x_rdy),
    .req_y_vld   (req_y_vld),
    .req_y       (req_y),
    .isqrt_x_vld (isqrt_x_vld),
    .isqrt_x     (isqrt_x),
    .isqrt_y_vld (isqrt_y_vld),
    .isqrt_y     (isqrt_y),
    .err_orphan  (err_orphan)
`ifdef ISQRT_RR_ARBITER_PERF_EN
    ,
    .perf_grants (perf_grants)
`endif
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks at the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_x_vld   = '0;
    req_x       = '0;
    isqrt_y_vld = 1'b0;
    isqrt_y     = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    req_x_vld   = 4'hF;
    req_x       = {32'd4, 32'd3, 32'd2, 32'd1};
    isqrt_y_vld = 1'b1;
    isqrt_y     = 16'h0055;
    #2;
    n_vec++;
    if (req_x_rdy !== 4'b0000) begin n_err++; $display("FAIL reset_rdy: got %b want 0000", req_x_rdy); end
    n_vec++;
    if (isqrt_x_vld !== 1'b0 || isqrt_x !== 32'd0) begin n_err++; $display("FAIL reset_isqrt_x: got vld=%b x=%0d want 0/0", isqrt_x_vld, isqrt_x); end
    n_vec++;
    if (req_y_vld !== 4'b0000 || req_y !== 16'd0) begin n_err++; $display("FAIL reset_req_y: got vld=%b y=%0d want 0000/0", req_y_vld, req_y); end
    n_vec++;
    if (err_orphan !== 1'b0) begin n_err++; $display("FAIL reset_orphan: got %b want 0", err_orphan); end
    $display("reset: outputs held low");
    do_reset();
  endtask

  task automatic test_single();
    req_x_vld = 4'b0001;
    req_x[31:0] = 32'd144;
    @(negedge clk);
    n_vec++;
    if (req_x_rdy !== 4'b0001 || isqrt_x_vld !== 1'b1 || isqrt_x !== 32'd144) begin
      n_err++; $display("FAIL single_grant: got rdy=%b vld=%b x=%0d want 0001/1/144", req_x_rdy, isqrt_x_vld, isqrt_x);
    end
    cyc();
    idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_vec++;
      if (req_y_vld !== 4'b0000) begin n_err++; $display("FAIL single_wait: got %b want 0000", req_y_vld); end
      cyc();
    end
    isqrt_y_vld = 1'b1;
    isqrt_y     = 16'd12;
    @(negedge clk);
    n_vec++;
    if (req_y_vld !== 4'b0001 || req_y !== 16'd12) begin
      n_err++; $display("FAIL single_result: got vld=%b y=%0d want 0001/12", req_y_vld, req_y);
    end
    cyc();
    idle();
    n_vec++;
    if (err_orphan !== 1'b0) begin n_err++; $display("FAIL single_orphan: got %b want 0", err_orphan); end
    $display("single: 144 -> 12 on requester 0");
  endtask

  task automatic test_round_robin();
    do_reset();
    req_x_vld = 4'hF;
    req_x = {32'd103, 32'd102, 32'd101, 32'd100};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_vec++;
      if (req_x_rdy !== 4'(1 << (c % 4)) || isqrt_x !== 32'(100 + c % 4)) begin
        n_err++; $display("FAIL rr_grant%0d: got rdy=%b x=%0d want %b/%0d", c, req_x_rdy, isqrt_x, 4'(1 << (c % 4)), 100 + c % 4);
      end
      $display("rr: cycle %0d grant %b", c, req_x_rdy);
      cyc();
    end
  endtask

  task automatic test_tag_full();
    do_reset();
    req_x_vld = 4'hF;
    req_x = {32'd16, 32'd9, 32'd4, 32'd1};
    for (int c = 0; c < 8; c++) cyc();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (req_x_rdy !== 4'b0000 || isqrt_x_vld !== 1'b0) begin
        n_err++; $display("FAIL full_stall%0d: got rdy=%b vld=%b want 0000/0", c, req_x_rdy, isqrt_x_vld);
      end
      cyc();
    end
    isqrt_y_vld = 1'b1;
    isqrt_y     = 16'd1;
    @(negedge clk);
    n_vec++;
    if (req_x_rdy !== 4'b0001 || req_y_vld !== 4'b0001) begin
      n_err++; $display("FAIL full_result_grant: got rdy=%b yvld=%b want 0001/0001", req_x_rdy, req_y_vld);
    end
    $display("full: grant in result cycle rdy=%b", req_x_rdy);
    cyc();
    req_x_vld = '0;
    for (int k = 0; k < 8; k++) begin
      isqrt_y = 16'(k + 2);
      @(negedge clk);
      n_vec++;
      if (req_y_vld !== 4'(1 << ((k + 1) % 4)) || req_y !== 16'(k + 2)) begin
        n_err++; $display("FAIL full_drain%0d: got vld=%b y=%0d want %b/%0d", k, req_y_vld, req_y, 4'(1 << ((k + 1) % 4)), k + 2);
      end
      cyc();
    end
    idle();
    n_vec++;
    if (err_orphan !== 1'b0) begin n_err++; $display("FAIL full_orphan: got %b want 0", err_orphan); end
  endtask

  task automatic test_routing();
    logic [3:0] exp_vld [3];
    logic [15:0] exp_y [3];
    exp_vld[0] = 4'b0100; exp_vld[1] = 4'b0001; exp_vld[2] = 4'b1000;
    exp_y[0] = 16'd2; exp_y[1] = 16'd3; exp_y[2] = 16'd4;
    do_reset();
    req_x_vld = 4'b0100; req_x[95:64] = 32'd4;
    @(negedge clk);
    n_vec++;
    if (req_x_rdy !== 4'b0100 || isqrt_x !== 32'd4) begin n_err++; $display("FAIL route_issue2: got rdy=%b x=%0d want 0100/4", req_x_rdy, isqrt_x); end
    cyc();
    req_x_vld = 4'b0001; req_x[31:0] = 32'd9;
    @(negedge clk);
    n_vec++;
    if (req_x_rdy !== 4'b0001 || isqrt_x !== 32'd9) begin n_err++; $display("FAIL route_issue0: got rdy=%b x=%0d want 0001/9", req_x_rdy, isqrt_x); end
    cyc();
    req_x_vld = 4'b1000; req_x[127:96] = 32'd16;
    @(negedge clk);
    n_vec++;
    if (req_x_rdy !== 4'b1000 || isqrt_x !== 32'd16) begin n_err++; $display("FAIL route_issue3: got rdy=%b x=%0d want 1000/16", req_x_rdy, isqrt_x); end
    cyc();
    req_x_vld = '0;
    isqrt_y_vld = 1'b1;
    for (int k = 0; k < 3; k++) begin
      isqrt_y = exp_y[k];
      @(negedge clk);
      n_vec++;
      if (req_y_vld !== exp_vld[k] || req_y !== exp_y[k]) begin
        n_err++; $display("FAIL route_result%0d: got vld=%b y=%0d want %b/%0d", k, req_y_vld, req_y, exp_vld[k], exp_y[k]);
      end
      $display("route: result %0d to %b", req_y, req_y_vld);
      cyc();
    end
    idle();
  endtask

  task automatic test_orphan();
    do_reset();
    isqrt_y_vld = 1'b1;
    isqrt_y     = 16'd7;
    @(negedge clk);
    n_vec++;
    if (req_y_vld !== 4'b0000) begin n_err++; $display("FAIL orphan_no_vld: got %b want 0000", req_y_vld); end
    cyc();
    idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (err_orphan !== 1'b1) begin n_err++; $display("FAIL orphan_sticky%0d: got %b want 1", c, err_orphan); end
      cyc();
    end
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (err_orphan !== 1'b0) begin n_err++; $display("FAIL orphan_clear: got %b want 0", err_orphan); end
    $display("orphan: flag set, held, cleared by reset");
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_x_vld = 4'b1110;
    req_x = {32'd3, 32'd2, 32'd1, 32'd0};
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_vec++;
      if (req_x_rdy !== 4'(1 << c)) begin n_err++; $display("FAIL mid_issue%0d: got %b want %b", c, req_x_rdy, 4'(1 << c)); end
      cyc();
    end
    isqrt_y_vld = 1'b1;
    isqrt_y     = 16'd5;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (req_x_rdy !== 4'b0000 || isqrt_x_vld !== 1'b0 || req_y_vld !== 4'b0000 || req_y !== 16'd0) begin
      n_err++; $display("FAIL mid_reset_out: got rdy=%b xv=%b yv=%b y=%0d want all 0", req_x_rdy, isqrt_x_vld, req_y_vld, req_y);
    end
    cyc();
    rst_n = 1'b1;
    req_x_vld = 4'hF;
    isqrt_y_vld = 1'b1;
    isqrt_y = 16'd9;
    @(negedge clk);
    n_vec++;
    if (req_x_rdy !== 4'b0001 || req_y_vld !== 4'b0000) begin
      n_err++; $display("FAIL mid_after: got rdy=%b yvld=%b want 0001/0000", req_x_rdy, req_y_vld);
    end
    cyc();
    idle();
    n_vec++;
    if (err_orphan !== 1'b1) begin n_err++; $display("FAIL mid_orphan: got %b want 1", err_orphan); end
    $display("reset_mid: tags discarded, requester 0 first");
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    cyc();
    test_reset();
    test_single();
    test_round_robin();
    test_tag_full();
    test_routing();
    test_orphan();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
